// File: rtl/vending_machine_multi_pkg.sv
// Shared types and constants for the multi-item vending controller.
package vending_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PAY, ST_VEND, ST_REFUND} state_t;
  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;
endpackage

// File: rtl/vending_machine_multi_if.sv
// Front-end / dispenser bundle of the vending controller.
interface vending_machine_multi_if #(
  parameter int NUM_ITEMS = 4,
  parameter int STOCK_W   = 4,
  parameter int CREDIT_W  = 4
);
  localparam int SEL_W = $clog2(NUM_ITEMS);
  logic                         sel_valid;
  logic [SEL_W-1:0]             sel;
  logic                         coin1;
  logic                         coin2;
  logic                         cancel;
  logic                         load_valid;
  logic [SEL_W-1:0]             load_sel;
  logic [STOCK_W-1:0]           load_qty;
  logic                         coin_accept;
  logic                         deliver;
  logic [SEL_W-1:0]             deliver_item;
  logic                         change_valid;
  logic [CREDIT_W-1:0]          change_amt;
  logic                         sold_out;
  logic [NUM_ITEMS*STOCK_W-1:0] stock_level;

  modport master (
    output sel_valid, sel, coin1, coin2, cancel, load_valid, load_sel, load_qty,
    input  coin_accept, deliver, deliver_item, change_valid, change_amt, sold_out, stock_level
  );
  modport slave (
    input  sel_valid, sel, coin1, coin2, cancel, load_valid, load_sel, load_qty,
    output coin_accept, deliver, deliver_item, change_valid, change_amt, sold_out, stock_level
  );
endinterface

// File: rtl/vending_machine_multi_stock_bank.sv
// Per-item saturating stock counters with one restock and one decrement port.
module stock_bank #(
  parameter int NUM_ITEMS = 4,
  parameter int STOCK_W   = 4,
  parameter int SEL_W     = $clog2(NUM_ITEMS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_en,
  input  logic [SEL_W-1:0]             ld_sel,
  input  logic [STOCK_W-1:0]           ld_qty,
  input  logic                         dec_en,
  input  logic [SEL_W-1:0]             dec_sel,
  output logic [NUM_ITEMS*STOCK_W-1:0] level
);
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
    logic [STOCK_W-1:0] cnt_q, cnt_d;
    logic [STOCK_W:0]   sum;

    assign sum = {1'b0, cnt_q} + {1'b0, ld_qty};

    // Restock saturates first, then a same-cycle vend takes one away.
    always_comb begin
      cnt_d = cnt_q;
      if (ld_en && ld_sel == SEL_W'(i))
        cnt_d = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
      if (dec_en && dec_sel == SEL_W'(i) && cnt_d != '0)
        cnt_d = cnt_d - STOCK_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign level[i*STOCK_W +: STOCK_W] = cnt_q;
  end
endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending FSM: selection, coin credit, timeout, vend/refund with change.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int                          NUM_ITEMS = 4,
  parameter int                          STOCK_W   = 4,
  parameter int                          CREDIT_W  = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES  = {4'd3, 4'd3, 4'd2, 4'd1},
  parameter int                          TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  vending_machine_multi_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_ITEMS);
  localparam int TMR_W = $clog2(TIMEOUT);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     item_q, item_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 coin_accept_q, coin_accept_d;
  logic                 deliver_q, deliver_d;
  logic [SEL_W-1:0]     deliver_item_q, deliver_item_d;
  logic                 change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0]  change_amt_q, change_amt_d;
  logic                 sold_out_q, sold_out_d;

  logic [NUM_ITEMS*STOCK_W-1:0] stock_lvl;
  logic [STOCK_W-1:0]   sel_stock;
  logic                 sel_ok;
  logic [CREDIT_W-1:0]  price;
  logic [CREDIT_W-1:0]  coin_add;
  logic                 coin_any;
  logic                 sel_avail;

  assign coin_add  = (bus.coin1 ? CREDIT_W'(COIN1_VAL) : '0) + (bus.coin2 ? CREDIT_W'(COIN2_VAL) : '0);
  assign coin_any  = bus.coin1 | bus.coin2;
  assign sel_avail = sel_ok && (sel_stock != '0);

  // Stock of the requested item and price of the latched item; out-of-range selects match nothing.
  always_comb begin
    sel_ok    = 1'b0;
    sel_stock = '0;
    price     = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        sel_stock = stock_lvl[i*STOCK_W +: STOCK_W];
      end
      if (item_q == SEL_W'(i)) price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  // State, credit and timeout register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      item_q   <= '0;
      credit_q <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      item_q   <= item_d;
      credit_q <= credit_d;
      tmr_q    <= tmr_d;
    end
  end

  // Next state: cancel beats payment completion, which beats timeout.
  always_comb begin
    state_d  = state_q;
    item_d   = item_q;
    credit_d = credit_q;
    tmr_d    = tmr_q;
    unique case (state_q)
      ST_IDLE: if (bus.sel_valid && sel_avail) begin
        item_d   = bus.sel;
        credit_d = '0;
        tmr_d    = '0;
        state_d  = ST_PAY;
      end
      ST_PAY: begin
        credit_d = credit_q + coin_add;
        tmr_d    = coin_any ? '0 : tmr_q + TMR_W'(1);
        if (bus.cancel)                                  state_d = ST_REFUND;
        else if (credit_d >= price)                      state_d = ST_VEND;
        else if (!coin_any && tmr_q == TMR_W'(TIMEOUT-1)) state_d = ST_REFUND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, computed from the transition being taken this cycle.
  always_comb begin
    coin_accept_d  = (state_d == ST_PAY);
    deliver_d      = (state_d == ST_VEND);
    deliver_item_d = deliver_item_q;
    change_amt_d   = change_amt_q;
    change_valid_d = 1'b0;
    sold_out_d     = (state_q == ST_IDLE) && bus.sel_valid && !sel_avail;
    if (state_d == ST_VEND) begin
      deliver_item_d = item_q;
      change_amt_d   = credit_d - price;
      change_valid_d = (credit_d != price);
    end else if (state_d == ST_REFUND) begin
      change_amt_d   = credit_d;
      change_valid_d = (credit_d != '0);
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin_accept_q  <= 1'b0;
      deliver_q      <= 1'b0;
      deliver_item_q <= '0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      sold_out_q     <= 1'b0;
    end else begin
      coin_accept_q  <= coin_accept_d;
      deliver_q      <= deliver_d;
      deliver_item_q <= deliver_item_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      sold_out_q     <= sold_out_d;
    end
  end

  stock_bank #(.NUM_ITEMS(NUM_ITEMS), .STOCK_W(STOCK_W), .SEL_W(SEL_W)) u_stock (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (bus.load_valid),
    .ld_sel  (bus.load_sel),
    .ld_qty  (bus.load_qty),
    .dec_en  (state_q == ST_VEND),
    .dec_sel (item_q),
    .level   (stock_lvl)
  );

  assign bus.coin_accept  = coin_accept_q;
  assign bus.deliver      = deliver_q;
  assign bus.deliver_item = deliver_item_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.stock_level  = stock_lvl;
endmodule
